// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Run controller for the single-cycle cpu core. It applies a
//               reset pulse of RST_CYCLES, enables the core for at most
//               RUN_CYCLES cycles, and counts the cycles in which res_zero and
//               equal are asserted. A run stops on the cycle budget, on an
//               equal streak (optional), or on abort, and reports why.
// Ports       : clk         - system clock, rising edge
//               reset       - synchronous active-high reset
//               start       - begin a run (accepted in IDLE/DONE only)
//               abort       - end an active run (RESET/RUN)
//               res_zero    - core ALU-zero flag, sampled in RUN
//               equal       - core compare flag, sampled in RUN
//               cpu_reset   - core reset
//               cpu_en      - core clock enable
//               busy        - run in progress (RESET or RUN)
//               done        - run finished, results valid
//               reason      - 0 none, 1 budget, 2 equal streak, 3 abort
//               cycle_count - RUN cycles elapsed
//               zero_count  - RUN cycles with res_zero = 1
//               equal_count - RUN cycles with equal = 1
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
  parameter int CNT_W         = 16,
  parameter int RUN_CYCLES    = 44,
  parameter int RST_CYCLES    = 2,
  parameter int STOP_ON_EQUAL = 0,
  parameter int EQ_HOLD       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             res_zero,
  input  logic             equal,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       reason,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] zero_count,
  output logic [CNT_W-1:0] equal_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0]       R_NONE   = 2'd0;
  localparam logic [1:0]       R_BUDGET = 2'd1;
  localparam logic [1:0]       R_EQUAL  = 2'd2;
  localparam logic [1:0]       R_ABORT  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_LIM  = CNT_W'(RUN_CYCLES);
  localparam logic [CNT_W-1:0] EQ_LIM   = CNT_W'(EQ_HOLD);
  localparam logic [7:0]       RST_LIM  = 8'(RST_CYCLES);

  state_t           state;
  logic [7:0]       rst_cnt;
  logic [CNT_W-1:0] eq_run;

  // Post-update values for the current RUN cycle; exit decisions use these
  // so the flag sample on the exiting cycle is included in the counts.
  logic [CNT_W-1:0] cyc_nxt;
  logic [CNT_W-1:0] zero_nxt;
  logic [CNT_W-1:0] eqc_nxt;
  logic [CNT_W-1:0] eq_run_nxt;

  // Saturating increment: counters stick at all-ones rather than wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    if (inc && (v != CNT_MAX)) begin
      return v + CNT_ONE;
    end
    return v;
  endfunction

  always_comb begin
    cyc_nxt    = sat_inc(cycle_count, 1'b1);
    zero_nxt   = sat_inc(zero_count, res_zero);
    eqc_nxt    = sat_inc(equal_count, equal);
    eq_run_nxt = equal ? sat_inc(eq_run, 1'b1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cpu_reset   <= 1'b1;
      cpu_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      reason      <= R_NONE;
      cycle_count <= '0;
      zero_count  <= '0;
      equal_count <= '0;
      rst_cnt     <= '0;
      eq_run      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // start has priority over a simultaneous abort here.
          if (start) begin
            state       <= S_RESET;
            cpu_reset   <= 1'b1;
            cpu_en      <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            reason      <= R_NONE;
            cycle_count <= '0;
            zero_count  <= '0;
            equal_count <= '0;
            rst_cnt     <= '0;
            eq_run      <= '0;
          end
        end

        S_RESET: begin
          if (abort) begin
            state     <= S_DONE;
            cpu_reset <= 1'b0;
            cpu_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            reason    <= R_ABORT;
          end else begin
            rst_cnt <= rst_cnt + 8'd1;
            if ((rst_cnt + 8'd1) == RST_LIM) begin
              state     <= S_RUN;
              cpu_reset <= 1'b0;
            end
          end
        end

        S_RUN: begin
          cycle_count <= cyc_nxt;
          zero_count  <= zero_nxt;
          equal_count <= eqc_nxt;
          eq_run      <= eq_run_nxt;
          if (abort) begin
            state  <= S_DONE;
            cpu_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            reason <= R_ABORT;
          end else if ((STOP_ON_EQUAL != 0) && (eq_run_nxt >= EQ_LIM)) begin
            state  <= S_DONE;
            cpu_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            reason <= R_EQUAL;
          end else if (cyc_nxt == RUN_LIM) begin
            state  <= S_DONE;
            cpu_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            reason <= R_BUDGET;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Scoreboard bench for cpu_run_ctrl. Three instances cover the
//               default configuration, equal-streak stop (EQ_HOLD=3) and a
//               narrow 4-bit counter build. The driver computes each run's
//               outcome from its flag sequence and queues it; the monitor
//               pops an entry whenever an instance drops busy and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

  localparam int NI   = 3;
  localparam int RSTC = 2;

  function automatic int run_lim(input int i);
    return (i == 2) ? 15 : 44;
  endfunction
  function automatic int cnt_max(input int i);
    return (i == 2) ? 15 : 65535;
  endfunction
  function automatic bit soe(input int i);
    return (i == 1);
  endfunction
  function automatic int eqh(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  typedef struct {
    int inst;
    bit is_rst;
    int reason;
    int cyc;
    int zc;
    int ec;
    int rc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst    = '1;
  logic [NI-1:0] start  = '0;
  logic [NI-1:0] abort  = '0;
  logic [NI-1:0] rz     = '0;
  logic [NI-1:0] eq     = '0;

  wire  [NI-1:0]       cpu_reset_o;
  wire  [NI-1:0]       cpu_en_o;
  wire  [NI-1:0]       busy_o;
  wire  [NI-1:0]       done_o;
  wire  [NI-1:0][1:0]  rsn_o;
  wire  [NI-1:0][15:0] cyc_o;
  wire  [NI-1:0][15:0] zc_o;
  wire  [NI-1:0][15:0] ec_o;

  cpu_run_ctrl u_def (
    .clk(clk), .reset(rst[0]), .start(start[0]), .abort(abort[0]),
    .res_zero(rz[0]), .equal(eq[0]),
    .cpu_reset(cpu_reset_o[0]), .cpu_en(cpu_en_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .reason(rsn_o[0]), .cycle_count(cyc_o[0]),
    .zero_count(zc_o[0]), .equal_count(ec_o[0])
  );

  cpu_run_ctrl #(.STOP_ON_EQUAL(1), .EQ_HOLD(3)) u_eqs (
    .clk(clk), .reset(rst[1]), .start(start[1]), .abort(abort[1]),
    .res_zero(rz[1]), .equal(eq[1]),
    .cpu_reset(cpu_reset_o[1]), .cpu_en(cpu_en_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .reason(rsn_o[1]), .cycle_count(cyc_o[1]),
    .zero_count(zc_o[1]), .equal_count(ec_o[1])
  );

  cpu_run_ctrl #(.CNT_W(4), .RUN_CYCLES(15)) u_small (
    .clk(clk), .reset(rst[2]), .start(start[2]), .abort(abort[2]),
    .res_zero(rz[2]), .equal(eq[2]),
    .cpu_reset(cpu_reset_o[2]), .cpu_en(cpu_en_o[2]), .busy(busy_o[2]),
    .done(done_o[2]), .reason(rsn_o[2]), .cycle_count(cyc_o[2][3:0]),
    .zero_count(zc_o[2][3:0]), .equal_count(ec_o[2][3:0])
  );
  assign cyc_o[2][15:4] = '0;
  assign zc_o[2][15:4]  = '0;
  assign ec_o[2][15:4]  = '0;

  task automatic chk(input string name, input int inst, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver. zmode: 0 random, 1 all ones. emode: 0 random, 1 toggle from 1,
  // 2 high from RUN cycle 10, 3 random biased high. ab_at: 0 none, -1 during
  // RESET, k on RUN cycle k. rst_at: k asserts reset on RUN cycle k.
  // --------------------------------------------------------------------------
  task automatic do_run(input int i, input int zmode, input int emode,
                        input int ab_at, input int rst_at, input bit sw_abort);
    logic zf [1:64];
    logic ef [1:64];
    exp_t e;
    int   n;
    int   streak;
    int   stop;
    n = run_lim(i);
    for (int k = 1; k <= 64; k++) begin
      zf[k] = (zmode == 1) ? 1'b1 : 1'($urandom % 2);
      case (emode)
        1:       ef[k] = (k % 2) == 1;
        2:       ef[k] = (k >= 10);
        3:       ef[k] = ($urandom % 4) != 0;
        default: ef[k] = 1'($urandom % 2);
      endcase
    end

    e = '{inst: i, is_rst: 1'b0, reason: 0, cyc: 0, zc: 0, ec: 0, rc: RSTC};
    stop = 0;
    if (rst_at > 0) begin
      e.is_rst = 1'b1;
      stop = rst_at;
    end else if (ab_at < 0) begin
      e.reason = 3;
      e.rc = 1;
    end else begin
      streak = 0;
      for (int k = 1; k <= n; k++) begin
        e.cyc  = (k > cnt_max(i)) ? cnt_max(i) : k;
        if (zf[k] && e.zc < cnt_max(i)) e.zc++;
        if (ef[k] && e.ec < cnt_max(i)) e.ec++;
        streak = ef[k] ? streak + 1 : 0;
        stop = k;
        if (k == ab_at) begin
          e.reason = 3; break;
        end else if (soe(i) && streak >= eqh(i)) begin
          e.reason = 2; break;
        end else if (k == n) begin
          e.reason = 1;
        end
      end
    end
    sbq.push_back(e);

    @(negedge clk);
    start[i] = 1'b1;
    abort[i] = sw_abort;
    @(negedge clk);
    start[i] = 1'b0;
    abort[i] = (ab_at < 0);
    if (ab_at >= 0) begin
      repeat (RSTC - 1) @(negedge clk);
      for (int k = 1; k <= stop; k++) begin
        @(negedge clk);
        rz[i]    = zf[k];
        eq[i]    = ef[k];
        abort[i] = (k == ab_at);
        start[i] = (k == 3) && (stop > 3);
        rst[i]   = (k == rst_at);
      end
    end
    @(negedge clk);
    rz[i] = 1'b0; eq[i] = 1'b0; abort[i] = 1'b1; start[i] = 1'b0; rst[i] = 1'b0;
    // abort while idle/done must be ignored; flags are don't-care here
    @(negedge clk);
    abort[i] = 1'b0;
    rz[i] = 1'($urandom % 2);
    eq[i] = 1'($urandom % 2);
    repeat (2) @(negedge clk);
    rz[i] = 1'b0; eq[i] = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  logic [NI-1:0] pbusy = '0;
  int   rcnt [NI];
  int   runc [NI];
  exp_t cur  [NI];
  bit   curv [NI];
  exp_t me;

  initial begin
    for (int i = 0; i < NI; i++) begin
      rcnt[i] = 0; runc[i] = 0; curv[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (busy_o[i] && !pbusy[i]) begin
        rcnt[i] = 0; runc[i] = 0;
      end
      if (busy_o[i]) begin
        if (cpu_reset_o[i] && cpu_en_o[i]) rcnt[i]++;
        else if (!cpu_reset_o[i] && cpu_en_o[i]) runc[i]++;
      end
      if (pbusy[i] && !busy_o[i]) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_end[%0d]: busy fell with empty scoreboard", i);
        end else begin
          me = sbq.pop_front();
          chk("inst", i, i, me.inst);
          if (me.is_rst) begin
            chk("rst_done", i, int'(done_o[i]), 0);
            chk("rst_reason", i, int'(rsn_o[i]), 0);
            chk("rst_cycle", i, int'(cyc_o[i]), 0);
            chk("rst_zero", i, int'(zc_o[i]), 0);
            chk("rst_equal", i, int'(ec_o[i]), 0);
            chk("rst_cpu_reset", i, int'(cpu_reset_o[i]), 1);
            chk("rst_cpu_en", i, int'(cpu_en_o[i]), 0);
          end else begin
            cur[i]  = me;
            curv[i] = 1'b1;
            chk("reset_cycles", i, rcnt[i], me.rc);
            chk("run_cycles", i, runc[i], me.cyc);
            chk("done_cpu_en", i, int'(cpu_en_o[i]), 0);
            chk("done_cpu_reset", i, int'(cpu_reset_o[i]), 0);
          end
        end
      end
      if (curv[i]) begin
        if (done_o[i]) begin
          chk("reason", i, int'(rsn_o[i]), cur[i].reason);
          chk("cycle_count", i, int'(cyc_o[i]), cur[i].cyc);
          chk("zero_count", i, int'(zc_o[i]), cur[i].zc);
          chk("equal_count", i, int'(ec_o[i]), cur[i].ec);
        end else begin
          curv[i] = 1'b0;
        end
      end
      pbusy[i] = busy_o[i];
    end
  end

  // --------------------------------------------------------------------------
  // Sequence
  // --------------------------------------------------------------------------
  initial begin
    int ab;
    int wait_cnt;
    rst = '1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("init_cpu_reset", i, int'(cpu_reset_o[i]), 1);
      chk("init_cpu_en", i, int'(cpu_en_o[i]), 0);
      chk("init_busy", i, int'(busy_o[i]), 0);
      chk("init_done", i, int'(done_o[i]), 0);
      chk("init_reason", i, int'(rsn_o[i]), 0);
      chk("init_cycle", i, int'(cyc_o[i]), 0);
    end
    rst = '0;
    @(negedge clk);

    // default build
    do_run(0, 1, 1, 0, 0, 1'b0);   // zero=44, equal=22, budget
    do_run(0, 0, 0, 5, 0, 1'b0);   // abort on RUN cycle 5
    do_run(0, 0, 0, 0, 0, 1'b1);   // start+abort in DONE: start wins
    do_run(0, 0, 0, 0, 20, 1'b0);  // reset mid-run
    do_run(0, 0, 0, -1, 0, 1'b0);  // abort during RESET
    do_run(0, 0, 3, 0, 0, 1'b0);   // equal streaks ignored without stop
    for (int r = 0; r < 4; r++) begin
      ab = (($urandom % 3) == 0) ? int'($urandom_range(1, 44)) : 0;
      do_run(0, 0, 0, ab, 0, 1'($urandom % 2));
    end

    // equal-streak build
    do_run(1, 0, 2, 0, 0, 1'b0);   // stop at cycle 12, equal_count 3
    for (int r = 0; r < 6; r++) begin
      ab = (($urandom % 4) == 0) ? int'($urandom_range(1, 20)) : 0;
      do_run(1, 0, (r % 2 == 0) ? 3 : 0, ab, 0, 1'b0);
    end
    do_run(1, 0, 0, 0, 0, 1'b0);

    // narrow counters
    do_run(2, 1, 0, 0, 0, 1'b0);   // 15 cycles, zero_count 15, no wrap
    do_run(2, 0, 0, 0, 0, 1'b0);
    do_run(2, 1, 3, 7, 0, 1'b0);

    wait_cnt = 0;
    while (sbq.size() != 0 && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d scoreboard entries outstanding, required 0", sbq.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
